// File: rtl/adder_share_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// adder_share_scheduler_pkg
//   Shared definitions for the adder share scheduler:
//     - sched_state_e : FSM state codes (IDLE=0, CALC=1, RESP=2)
//     - clog2_min1    : ceil(log2(n)) clamped to at least 1, used for ID_W
// -----------------------------------------------------------------------------
package adder_share_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } sched_state_e;

   // Width needed to encode n distinct values; a single requester ID still
   // gets one bit so that ID ports never collapse to zero width.
   function automatic int clog2_min1(input int n);
      int r;
      r = 32'sd0;
      while ((32'sd1 << r) < n) begin
         r = r + 32'sd1;
      end
      return (r < 32'sd1) ? 32'sd1 : r;
   endfunction

endpackage

// File: rtl/adder_share_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. The search starts one past the last winner and wraps;
//   the first asserted Valid bit wins.
//   Ports:
//     Clk, Rst_n : clock, asynchronous active-low reset
//     Valid      : request vector
//     Update     : grant was taken this cycle; remember Grant_id as last winner
//     Grant      : one-hot grant (zero when no Valid)
//     Grant_id   : encoded index of Grant
//     Any        : at least one requester is valid
// -----------------------------------------------------------------------------
module rr_arbiter
   import adder_share_scheduler_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = clog2_min1(NUM_REQ)
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic [NUM_REQ-1:0] Valid,
   input  logic               Update,
   output logic [NUM_REQ-1:0] Grant,
   output logic [ID_W-1:0]    Grant_id,
   output logic               Any
);

   logic [ID_W-1:0] ptr_r;
   logic [ID_W-1:0] cand_s;
   logic            found_s;
   logic            hit_s;

   // Priority search from ptr_r+1 around the ring; first valid candidate wins.
   always_comb begin
      Grant    = '0;
      Grant_id = '0;
      found_s  = 1'b0;
      hit_s    = 1'b0;
      cand_s   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s        = ID_W'((int'(ptr_r) + k) % NUM_REQ);
         hit_s         = !found_s && Valid[cand_s];
         Grant[cand_s] = Grant[cand_s] | hit_s;
         Grant_id      = hit_s ? cand_s : Grant_id;
         found_s       = found_s | hit_s;
      end
      Any = found_s;
   end

   // Last-winner pointer; resets to NUM_REQ-1 so requester 0 is searched first.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ptr_r <= ID_W'(NUM_REQ - 1);
      end else if (Update) begin
         ptr_r <= Grant_id;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/adder_share_scheduler.sv
// -----------------------------------------------------------------------------
// adder_share_scheduler
//   Shares one registered WIDTH-bit adder among NUM_REQ requesters.
//   Ports:
//     Clk, Rst_n : clock, asynchronous active-low reset
//     Req_valid  : per-requester operand-pair valid
//     Req_A/B    : requester i operands at [i*WIDTH +: WIDTH]
//     Req_ready  : one-hot (or zero) accept, combinational, IDLE only
//     Rsp_valid  : response available (held until Rsp_ready)
//     Rsp_id     : owner of the response
//     Rsp_sum    : {carry, sum} of the owner's operands
//     Rsp_ready  : consumer accepts the response
//     Busy       : FSM is not in IDLE
// -----------------------------------------------------------------------------
module adder_share_scheduler
   import adder_share_scheduler_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 2,
   localparam int ID_W    = clog2_min1(NUM_REQ)
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic [NUM_REQ-1:0]       Req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] Req_A,
   input  logic [NUM_REQ*WIDTH-1:0] Req_B,
   output logic [NUM_REQ-1:0]       Req_ready,
   output logic                     Rsp_valid,
   output logic [ID_W-1:0]          Rsp_id,
   output logic [WIDTH:0]           Rsp_sum,
   input  logic                     Rsp_ready,
   output logic                     Busy
);

   sched_state_e       state_r;
   sched_state_e       state_nxt_s;

   logic [NUM_REQ-1:0] grant_s;
   logic [ID_W-1:0]    grant_id_s;
   logic               any_s;
   logic               req_hs_s;

   logic [WIDTH-1:0]   op_a_r;
   logic [WIDTH-1:0]   op_b_r;
   logic [ID_W-1:0]    op_id_r;

   logic               rsp_valid_r;
   logic [ID_W-1:0]    rsp_id_r;
   logic [WIDTH:0]     rsp_sum_r;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Valid    (Req_valid),
      .Update   (req_hs_s),
      .Grant    (grant_s),
      .Grant_id (grant_id_s),
      .Any      (any_s)
   );

   // Ready only in IDLE and never during reset; any offered request completes.
   always_comb begin
      Req_ready = '0;
      req_hs_s  = 1'b0;
      if (Rst_n && (state_r == ST_IDLE)) begin
         Req_ready = grant_s;
         req_hs_s  = any_s;
      end else begin
         Req_ready = '0;
         req_hs_s  = 1'b0;
      end
   end

   // Next-state logic: IDLE -> CALC on handshake, CALC -> RESP, RESP -> IDLE on accept.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_hs_s) state_nxt_s = ST_CALC;
            else          state_nxt_s = ST_IDLE;
         end
         ST_CALC: state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (Rsp_ready) state_nxt_s = ST_IDLE;
            else           state_nxt_s = ST_RESP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Capture the granted requester's operands and ID at the handshake edge.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         op_a_r  <= '0;
         op_b_r  <= '0;
         op_id_r <= '0;
      end else if (req_hs_s) begin
         op_a_r  <= Req_A[int'(grant_id_s) * WIDTH +: WIDTH];
         op_b_r  <= Req_B[int'(grant_id_s) * WIDTH +: WIDTH];
         op_id_r <= grant_id_s;
      end else begin
         op_a_r  <= op_a_r;
         op_b_r  <= op_b_r;
         op_id_r <= op_id_r;
      end
   end

   // Registered add stage and response holding registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_sum_r   <= '0;
      end else if (state_r == ST_CALC) begin
         // Zero-extend both operands so the carry lands in the MSB.
         rsp_sum_r   <= {1'b0, op_a_r} + {1'b0, op_b_r};
         rsp_id_r    <= op_id_r;
         rsp_valid_r <= 1'b1;
      end else if ((state_r == ST_RESP) && Rsp_ready) begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= rsp_id_r;
         rsp_sum_r   <= rsp_sum_r;
      end else begin
         rsp_valid_r <= rsp_valid_r;
         rsp_id_r    <= rsp_id_r;
         rsp_sum_r   <= rsp_sum_r;
      end
   end

   assign Rsp_valid = rsp_valid_r;
   assign Rsp_id    = rsp_id_r;
   assign Rsp_sum   = rsp_sum_r;
   assign Busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_adder_share_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adder_share_scheduler
//   Directed bench for adder_share_scheduler (NUM_REQ=4, WIDTH=2).
//   Inputs are driven 1 time unit after a rising edge; outputs are sampled
//   on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adder_share_scheduler;

   logic       Clk;
   logic       Rst_n;
   logic [3:0] Req_valid;
   logic [7:0] Req_A;
   logic [7:0] Req_B;
   logic [3:0] Req_ready;
   logic       Rsp_valid;
   logic [1:0] Rsp_id;
   logic [2:0] Rsp_sum;
   logic       Rsp_ready;
   logic       Busy;

   int n_checks = 0;
   int n_errors = 0;
   int pass_cnt = 0;

   adder_share_scheduler #(
      .NUM_REQ (4),
      .WIDTH   (2)
   ) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Req_valid (Req_valid),
      .Req_A     (Req_A),
      .Req_B     (Req_B),
      .Req_ready (Req_ready),
      .Rsp_valid (Rsp_valid),
      .Rsp_id    (Rsp_id),
      .Rsp_sum   (Rsp_sum),
      .Rsp_ready (Rsp_ready),
      .Busy      (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_ops(input int r, input int a, input int b);
      Req_A[r*2 +: 2] = a[1:0];
      Req_B[r*2 +: 2] = b[1:0];
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
   endtask

   // One full transaction with Rsp_ready high: grant, CALC, RESP, accept.
   // Called 1 unit after a rising edge; returns 1 unit after the accept edge.
   task automatic run_op(input int exp_id, input int exp_sum, input logic [3:0] drop);
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0001 << exp_id;
      @(negedge Clk);
      check_val($sformatf("grant_%0d", exp_id), Req_ready, exp_rdy);
      @(posedge Clk);
      #1;
      Req_valid = Req_valid & ~drop;
      @(negedge Clk);
      check_val("calc_busy", Busy, 1);
      check_val("calc_ready", Req_ready, 0);
      check_val("calc_rsp_valid", Rsp_valid, 0);
      @(posedge Clk);
      @(negedge Clk);
      check_val("rsp_valid", Rsp_valid, 1);
      check_val("rsp_id", Rsp_id, exp_id);
      check_val($sformatf("rsp_sum_id%0d", exp_id), Rsp_sum, exp_sum);
      check_val("rsp_ready_low", Req_ready, 0);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Rst_n     = 1'b0;
      Req_valid = 4'hF;
      Req_A     = 8'h00;
      Req_B     = 8'h00;
      Rsp_ready = 1'b1;

      // Reset state, including no ready while reset is held with valids up
      #12;
      check_val("rst_rsp_valid", Rsp_valid, 0);
      check_val("rst_rsp_id", Rsp_id, 0);
      check_val("rst_rsp_sum", Rsp_sum, 0);
      check_val("rst_busy", Busy, 0);
      check_val("rst_req_ready", Req_ready, 0);
      Req_valid = 4'h0;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;

      // 1: single request from requester 2, max sum 3+3=6
      set_ops(2, 3, 3);
      Req_valid = 4'b0100;
      run_op(2, 6, 4'b0100);
      @(negedge Clk);
      check_val("t1_idle_busy", Busy, 0);
      check_val("t1_idle_rsp_valid", Rsp_valid, 0);
      @(posedge Clk);
      #1;

      // 2: round robin with all valid: A_i=i, B_i=(i+1)%4 -> sums 1,3,5,3
      do_reset();
      for (int i = 0; i < 4; i++) set_ops(i, i, (i + 1) % 4);
      Req_valid = 4'hF;
      run_op(0, 1, 4'b0000);
      run_op(1, 3, 4'b0000);
      run_op(2, 5, 4'b0000);
      run_op(3, 3, 4'b0000);
      run_op(0, 1, 4'b0000);
      Req_valid = 4'h0;
      @(posedge Clk);
      #1;

      // 3: pointer skip: after grant to 1, {3,0} valid -> 3 then wrap to 0
      do_reset();
      set_ops(1, 2, 1);
      set_ops(3, 3, 1);
      set_ops(0, 0, 0);
      Req_valid = 4'b0010;
      run_op(1, 3, 4'b0010);
      Req_valid = 4'b1001;
      run_op(3, 4, 4'b1000);
      run_op(0, 0, 4'b0001);
      @(negedge Clk);
      check_val("t3_no_ready", Req_ready, 0);
      check_val("t3_idle_busy", Busy, 0);
      @(posedge Clk);
      #1;

      // 4: backpressure in RESP for 5 cycles with all requesters valid
      do_reset();
      set_ops(0, 1, 2);
      set_ops(1, 3, 2);
      set_ops(2, 2, 2);
      set_ops(3, 1, 1);
      Rsp_ready = 1'b0;
      Req_valid = 4'hF;
      @(negedge Clk);
      check_val("t4_grant0", Req_ready, 4'b0001);
      @(posedge Clk);
      @(negedge Clk);
      check_val("t4_calc_busy", Busy, 1);
      @(posedge Clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         check_val("t4_hold_valid", Rsp_valid, 1);
         check_val("t4_hold_id", Rsp_id, 0);
         check_val("t4_hold_sum", Rsp_sum, 3);
         check_val("t4_hold_busy", Busy, 1);
         check_val("t4_hold_ready", Req_ready, 0);
         @(posedge Clk);
      end
      #1;
      Rsp_ready = 1'b1;
      @(negedge Clk);
      check_val("t4_release_valid", Rsp_valid, 1);
      @(posedge Clk);
      #1;
      Rsp_ready = 1'b0;
      @(negedge Clk);
      check_val("t4_next_grant", Req_ready, 4'b0010);
      check_val("t4_accept_valid", Rsp_valid, 0);
      @(posedge Clk);

      // 5: reset asserted mid-RESP clears outputs without a clock edge
      @(negedge Clk);
      check_val("t5_calc_busy", Busy, 1);
      @(posedge Clk);
      @(negedge Clk);
      check_val("t5_resp_valid", Rsp_valid, 1);
      check_val("t5_resp_sum", Rsp_sum, 5);
      #2;
      Rst_n = 1'b0;
      #1;
      check_val("t5_async_rsp_valid", Rsp_valid, 0);
      check_val("t5_async_busy", Busy, 0);
      check_val("t5_async_ready", Req_ready, 0);
      check_val("t5_async_sum", Rsp_sum, 0);
      @(posedge Clk);
      #1;
      Rst_n     = 1'b1;
      Rsp_ready = 1'b1;
      run_op(0, 3, 4'b0000);
      Req_valid = 4'h0;
      @(posedge Clk);
      #1;

      // 6: exhaustive: each requester walks all 16 {A,B}; 64 ops in RR order
      do_reset();
      for (int i = 0; i < 4; i++) set_ops(i, 0, 0);
      Req_valid = 4'hF;
      for (int k = 0; k < 64; k++) begin
         int r;
         int c;
         int a;
         int b;
         int e0;
         logic [3:0] drop;
         r    = k % 4;
         c    = k / 4;
         a    = c / 4;
         b    = c % 4;
         e0   = n_errors;
         drop = (c == 15) ? (4'b0001 << r) : 4'b0000;
         run_op(r, a + b, drop);
         if (n_errors == e0) pass_cnt++;
         if (c < 15) set_ops(r, (c + 1) / 4, (c + 1) % 4);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk);
         check_val("t6_no_extra_rsp", Rsp_valid, 0);
         check_val("t6_no_extra_busy", Busy, 0);
      end
      check_val("t6_pass_count", pass_cnt, 64);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
